// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared states, modes, op codes and operand clamp for calc_controller
package calc_pkg;

  localparam int OPERAND_MAX = 99;
  localparam int OPERAND_W   = 7;
  localparam int RESULT_W    = 14;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_SHOW
  } state_t;

  typedef enum logic [1:0] {
    MODE_NONE,
    MODE_ADD,
    MODE_SUB,
    MODE_MUL
  } mode_t;

  localparam logic [1:0] OPC_ADD = 2'b00;
  localparam logic [1:0] OPC_SUB = 2'b01;
  localparam logic [1:0] OPC_MUL = 2'b10;

  // Operands above the displayable two-digit range saturate at OPERAND_MAX.
  function automatic logic [OPERAND_W-1:0] clamp_operand(input logic [OPERAND_W-1:0] v);
    return (v > OPERAND_W'(OPERAND_MAX)) ? OPERAND_W'(OPERAND_MAX) : v;
  endfunction

  // NONE never reaches the datapath; it maps to add so 2'b11 is never produced.
  function automatic logic [1:0] mode_to_code(input mode_t m);
    case (m)
      MODE_SUB: return OPC_SUB;
      MODE_MUL: return OPC_MUL;
      default:  return OPC_ADD;
    endcase
  endfunction

endpackage

// File: rtl/calc_debounce.sv
// rtl/calc_debounce.sv - synchronizer plus debounce for one active-low button, pulses on release
module calc_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic release_event
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync_q1;
  logic             sync_q2;
  logic             level_q;
  logic [CNT_W-1:0] cnt_q;

  // Two-flop synchronizer; idle level is 1 (button released).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= btn_n;
      sync_q2 <= sync_q1;
    end
  end

  // Accept a new level after DEBOUNCE_CYCLES consecutive differing samples; pulse on 0->1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q       <= 1'b1;
      cnt_q         <= '0;
      release_event <= 1'b0;
    end else begin
      release_event <= 1'b0;
      if (sync_q2 == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_q       <= sync_q2;
        cnt_q         <= '0;
        release_event <= sync_q2;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/calc_controller.sv
// rtl/calc_controller.sv - calculator sequencer; optional WAIT timeout under CALC_TIMEOUT_EN
module calc_controller
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 b_lig,
  input  logic                 b_soma,
  input  logic                 b_sub,
  input  logic                 b_multi,
  input  logic [OPERAND_W-1:0] a_in,
  input  logic [OPERAND_W-1:0] b_in,
  output logic                 op_start,
  output logic [1:0]           op_code,
  output logic [OPERAND_W-1:0] op_a,
  output logic [OPERAND_W-1:0] op_b,
  input  logic                 op_done,
  input  logic [RESULT_W-1:0]  op_result,
  input  logic                 op_neg,
  output logic [RESULT_W-1:0]  y,
  output logic                 sinal,
  output logic                 en,
  output logic                 busy,
  output logic                 err
);

  logic ev_lig, ev_soma, ev_sub, ev_multi;

  calc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lig   (.clk(clk), .rst_n(rst_n), .btn_n(b_lig),   .release_event(ev_lig));
  calc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_soma  (.clk(clk), .rst_n(rst_n), .btn_n(b_soma),  .release_event(ev_soma));
  calc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sub   (.clk(clk), .rst_n(rst_n), .btn_n(b_sub),   .release_event(ev_sub));
  calc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_multi (.clk(clk), .rst_n(rst_n), .btn_n(b_multi), .release_event(ev_multi));

  logic                 lig_evt;
  logic                 op_evt;
  mode_t                evt_mode;
  logic [OPERAND_W-1:0] a_clamped;
  logic [OPERAND_W-1:0] b_clamped;

  state_t               state_q, state_d;
  mode_t                mode_q, mode_d;
  logic                 pend_valid_q, pend_valid_d;
  mode_t                pend_mode_q, pend_mode_d;
  logic [RESULT_W-1:0]  y_q, y_d;
  logic                 sinal_q, sinal_d;
  logic                 en_q, en_d;
  logic [1:0]           op_code_q, op_code_d;
  logic [OPERAND_W-1:0] op_a_q, op_a_d;
  logic [OPERAND_W-1:0] op_b_q, op_b_d;
  logic                 issue;
  logic                 go_off;
  mode_t                issue_mode;

`ifdef CALC_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
`endif

  assign a_clamped = clamp_operand(a_in);
  assign b_clamped = clamp_operand(b_in);

  // Fixed-priority resolve: lig beats all op buttons; only the highest op event survives.
  always_comb begin
    lig_evt  = ev_lig;
    op_evt   = 1'b0;
    evt_mode = MODE_NONE;
    if (!ev_lig) begin
      if (ev_soma) begin
        op_evt   = 1'b1;
        evt_mode = MODE_ADD;
      end else if (ev_sub) begin
        op_evt   = 1'b1;
        evt_mode = MODE_SUB;
      end else if (ev_multi) begin
        op_evt   = 1'b1;
        evt_mode = MODE_MUL;
      end
    end
  end

  // Next-state and next-output logic; issue/go_off apply the shared side effects at the end.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    pend_valid_d = pend_valid_q;
    pend_mode_d  = pend_mode_q;
    y_d          = y_q;
    sinal_d      = sinal_q;
    en_d         = en_q;
    op_code_d    = op_code_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    issue        = 1'b0;
    go_off       = 1'b0;
    issue_mode   = mode_q;
`ifdef CALC_TIMEOUT_EN
    tmo_d        = tmo_q;
    err_d        = err_q;
`endif
    case (state_q)
      ST_OFF: begin
        if (lig_evt) begin
          state_d = ST_IDLE;
          en_d    = 1'b1;
          y_d     = '0;
          sinal_d = 1'b0;
        end
      end
      ST_IDLE: begin
        if (lig_evt) begin
          go_off = 1'b1;
        end else if (op_evt) begin
          issue      = 1'b1;
          issue_mode = evt_mode;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        if (op_evt) begin
          pend_valid_d = 1'b1;
          pend_mode_d  = evt_mode;
        end
      end
      ST_WAIT: begin
        if (lig_evt) begin
          go_off = 1'b1;
        end else begin
          if (op_evt) begin
            pend_valid_d = 1'b1;
            pend_mode_d  = evt_mode;
          end
          if (op_done) begin
            y_d     = op_result;
            sinal_d = op_neg && (op_code_q == OPC_SUB);
            state_d = ST_SHOW;
          end
`ifdef CALC_TIMEOUT_EN
          else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            err_d   = 1'b1;
            y_d     = '0;
            sinal_d = 1'b0;
            state_d = ST_SHOW;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
`endif
        end
      end
      ST_SHOW: begin
        if (lig_evt) begin
          go_off = 1'b1;
        end else if (pend_valid_q) begin
          issue      = 1'b1;
          issue_mode = pend_mode_q;
        end else if (op_evt) begin
          issue      = 1'b1;
          issue_mode = evt_mode;
        end else if ((a_clamped != op_a_q) || (b_clamped != op_b_q)) begin
          issue = 1'b1;
        end
      end
      default: state_d = ST_OFF;
    endcase

    if (issue) begin
      state_d      = ST_ISSUE;
      mode_d       = issue_mode;
      op_code_d    = mode_to_code(issue_mode);
      op_a_d       = a_clamped;
      op_b_d       = b_clamped;
      pend_valid_d = 1'b0;
`ifdef CALC_TIMEOUT_EN
      tmo_d        = '0;
`endif
    end

    if (go_off) begin
      state_d      = ST_OFF;
      en_d         = 1'b0;
      y_d          = '0;
      sinal_d      = 1'b0;
      pend_valid_d = 1'b0;
`ifdef CALC_TIMEOUT_EN
      err_d        = 1'b0;
`endif
    end
  end

  // State and held-output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_OFF;
      mode_q       <= MODE_NONE;
      pend_valid_q <= 1'b0;
      pend_mode_q  <= MODE_NONE;
      y_q          <= '0;
      sinal_q      <= 1'b0;
      en_q         <= 1'b0;
      op_code_q    <= OPC_ADD;
      op_a_q       <= '0;
      op_b_q       <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      pend_valid_q <= pend_valid_d;
      pend_mode_q  <= pend_mode_d;
      y_q          <= y_d;
      sinal_q      <= sinal_d;
      en_q         <= en_d;
      op_code_q    <= op_code_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
    end
  end

`ifdef CALC_TIMEOUT_EN
  // Timeout counter and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign op_start = (state_q == ST_ISSUE);
  assign busy     = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign op_code  = op_code_q;
  assign op_a     = op_a_q;
  assign op_b     = op_b_q;
  assign y        = y_q;
  assign sinal    = sinal_q;
  assign en       = en_q;

endmodule

// File: doc/calc_controller.md
# calc_controller

Sequencer for the calculator's arithmetic datapath. Takes the four raw active-low push-buttons and the two 7-bit operand inputs, debounces the buttons and turns each release into an event. Runs the power/mode state machine and drives a shared add/sub/mul unit through a start/done handshake. Holds the displayed result, sign and display enable between operations.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized samples required before a button level is accepted.
- TIMEOUT_CYCLES, 16: maximum wait for `op_done` after `op_start` (used only with `CALC_TIMEOUT_EN`).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- b_lig, b_soma, b_sub, b_multi  in  1 each  raw buttons, active-low (0 = pressed).
- a_in, b_in  in  7  raw operands.
- op_start  out  1  one-cycle request to the datapath.
- op_code  out  2  00 = add, 01 = sub, 10 = mul; 11 is never driven.
- op_a, op_b  out  7  clamped operands; held stable from `op_start` until completion.
- op_done  in  1  one-cycle completion from the datapath.
- op_result  in  14  magnitude of the result.
- op_neg  in  1  result is negative (sub only).
- y  out  14  displayed magnitude.
- sinal  out  1  displayed sign.
- en  out  1  display enable.
- busy  out  1  high in ISSUE and WAIT.
- err  out  1  sticky timeout flag.

## Operation
- **Button path:** 2-flop synchronizer, then debounce.
  - Event = debounced level going 0→1 (release). Each release is one single-cycle event.
  - Simultaneous events are resolved by fixed priority lig > soma > sub > multi. Lower-priority events in the same cycle are dropped.
- **Clamp:** an operand above 99 becomes 99. Clamped values are snapshotted into `op_a`/`op_b` in ISSUE.
- **Mode register:** NONE/ADD/SUB/MUL. soma/sub/multi events set the mode.
- **FSM states and transitions:**
  - OFF: en=0, y=0, sinal=0. lig → IDLE.
  - IDLE: en=1, y=0, sinal=0. Op event → ISSUE. lig → OFF.
  - ISSUE: one cycle. `op_start`=1, `op_code` from mode. → WAIT.
  - WAIT: on `op_done`, latch y=`op_result` and sinal=`op_neg` (sinal forced 0 unless SUB), then → SHOW.
    - lig → OFF (abort); a later stray `op_done` is ignored.
    - An op event in WAIT is stored as a one-deep pending mode; a newer event overwrites it.
  - SHOW: → ISSUE if a pending mode exists, an op event occurs (the same op re-issues), or the clamped a_in/b_in differ from the snapshot. lig → OFF.
- Priority inside SHOW: lig > pending > new event > operand change.

## Timing
- **Reset values:** state=OFF, mode=NONE, y=0, sinal=0, en=0, op_start=0, op_code=00, op_a=op_b=0, busy=0, err=0, no pending event.
- **Reset mid-operation:** immediate return to reset values; the in-flight `op_done` is ignored.
- Raw release → event: 2 + DEBOUNCE_CYCLES cycles.
- Event at cycle t → ISSUE with `op_start` at t+1 → WAIT at t+2.
- `op_done` at cycle d → y/sinal updated and state=SHOW at d+1; `busy` low at d+1.
- An `op_done` in the same cycle as `op_start` is ignored.
- y and sinal change only at completion, at entry to OFF/IDLE, or on timeout.
- en changes one cycle after the lig event.

## Configuration
- `CALC_TIMEOUT_EN` defined:
  - WAIT counts cycles; at TIMEOUT_CYCLES without `op_done`, set err=1, y=0, sinal=0, → SHOW.
  - err clears only on reset or on entry to OFF.
- `CALC_TIMEOUT_EN` undefined: WAIT waits indefinitely; err tied to 0; no counter logic.

## Structure
- **calc_pkg:**
  - state enum (OFF, IDLE, ISSUE, WAIT, SHOW)
  - mode enum
  - op_code constants
  - OPERAND_MAX=99, OPERAND_W=7, RESULT_W=14
- **calc_debounce** sub-module: synchronizer, stable counter and release-event output. Instantiated four times.
- The priority resolver, clamp logic and FSM live in calc_controller.

## Test plan
- Reset → all outputs 0. Press/release lig for 10 cycles → en=1 at 2+4+1 cycles after release, y=0.
- In IDLE, a_in=120, b_in=5, soma release → `op_start` with op_a=99, op_b=5, op_code=00. Datapath returns 104 after 3 cycles → y=104, sinal=0.
- SUB with a_in=3, b_in=10, datapath returns 7/neg → y=7, sinal=1. Then change a_in to 20 in SHOW → automatic re-issue, y=10, sinal=0.
- soma and multi released in the same cycle → op_code=00 only; multi dropped.
- multi released while in WAIT → after `op_done`, immediate re-issue with op_code=10. lig released in WAIT → OFF; a late `op_done` leaves y=0, en=0.
- With `CALC_TIMEOUT_EN`, no `op_done` → err=1 after 16 WAIT cycles, y=0. rst_n pulsed mid-WAIT → reset values next cycle.
